// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// Latency: n/a (wiring only). Backpressure: none; all signals are plain levels or strobes.
// Ports: master drives en/div_load/div_val/mode_in and observes clk_o, ticks, running, div_cur;
//        slave is the divider side.
interface clk_div_prog_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             mode_in;
  logic             clk_o;
  logic             rise_tick;
  logic             fall_tick;
  logic             running;
  logic [CNT_W-1:0] div_cur;

  modport master (
    output en, div_load, div_val, mode_in,
    input  clk_o, rise_tick, fall_tick, running, div_cur
  );

  modport slave (
    input  en, div_load, div_val, mode_in,
    output clk_o, rise_tick, fall_tick, running, div_cur
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: 50% square (period 2(N+1)) or 1-cycle strobe (period N+1),
// with rise/fall tick strobes. Latency: clk_o and ticks registered together, zero skew between them.
// Backpressure: none; en stop is graceful (a high phase always completes before IDLE).
// Ports: clk, rst_n (async active-low), bus (slave modport of clk_div_prog_if).
module clk_div_prog #(
  parameter int          CNT_W     = 32,
  parameter int unsigned DIV_RESET = 49999
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_prog_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;       // terminal count in effect (div_cur)
  logic             pulse;      // active mode: 0 square, 1 pulse
  logic             pend;
  logic             pend_mode;
  logic [CNT_W-1:0] pend_val;
  logic             clk_q;
  logic             rise_q;
  logic             fall_q;
  logic             run_q;

  logic             at_term;
  logic             apply;
  logic             ld_mode;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] new_term;
  logic             nxt_out;
  logic [CNT_W-1:0] nxt_cnt;

  always_comb begin
    // A load on the apply edge itself wins over the stored shadow value.
    ld_mode  = bus.div_load ? bus.mode_in : pend_mode;
    ld_val   = bus.div_load ? bus.div_val : pend_val;
    at_term  = (cnt == term);
    apply    = (bus.div_load | pend) & ((state == IDLE) | at_term);
    // Pulse mode cannot run at N=0 (would need a 1-cycle period); clamp to 1.
    new_term = (ld_mode && (ld_val == '0)) ? CNT_W'(1) : ld_val;
    // Boundary action always uses the mode in effect before this edge.
    if (at_term) begin
      nxt_out = pulse | ~clk_q;
      nxt_cnt = '0;
    end else begin
      nxt_out = ~pulse & clk_q;
      nxt_cnt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      term      <= CNT_W'(DIV_RESET);
      pulse     <= 1'b0;
      pend      <= 1'b0;
      pend_mode <= 1'b0;
      pend_val  <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      if (apply) begin
        term  <= new_term;
        pulse <= ld_mode;
        pend  <= 1'b0;
      end else if (bus.div_load) begin
        pend      <= 1'b1;
        pend_val  <= bus.div_val;
        pend_mode <= bus.mode_in;
      end

      rise_q <= 1'b0;
      fall_q <= 1'b0;

      case (state)
        IDLE: begin
          cnt   <= '0;
          clk_q <= 1'b0;
          if (bus.en) begin
            state <= RUN;
            run_q <= 1'b1;
          end
        end
        RUN, STOP: begin
          if (!bus.en && !clk_q) begin
            // Stopping in a low phase: leave at once, output stays low, no tick.
            state <= IDLE;
            run_q <= 1'b0;
            cnt   <= '0;
          end else begin
            clk_q  <= nxt_out;
            rise_q <= nxt_out & ~clk_q;
            fall_q <= ~nxt_out & clk_q;
            if (!bus.en && !nxt_out) begin
              // Final high phase has just completed.
              state <= IDLE;
              run_q <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt   <= nxt_cnt;
              state <= bus.en ? RUN : STOP;
            end
          end
        end
        default: begin
          state <= IDLE;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_o     = clk_q;
  assign bus.rise_tick = rise_q;
  assign bus.fall_tick = fall_q;
  assign bus.running   = run_q;
  assign bus.div_cur   = term;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock/tick divider with graceful start/stop, the parametrised successor to the fixed 50 kHz-terminal divider. It generates a 50 %-duty square output or a single-cycle strobe from the system clock. It also emits rise/fall tick strobes for synchronous consumers such as display scan, debounce and UART baud logic. Divisor and mode changes are double-buffered and take effect only at a half-period boundary, so clk_o never glitches.

## Interface
- CNT_W, 32, counter / terminal-count width
- DIV_RESET, 49999, terminal count N active after reset (100 MHz → 1 kHz square)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request, level
- div_load  in  1  one-cycle strobe: capture div_val and mode_in
- div_val  in  CNT_W  new terminal count N
- mode_in  in  1  0 = square, 1 = pulse
- clk_o  out  1  divided output, registered
- rise_tick  out  1  high for the one cycle in which clk_o has just gone 0→1
- fall_tick  out  1  high for the one cycle in which clk_o has just gone 1→0
- running  out  1  high in RUN and STOP
- div_cur  out  CNT_W  terminal count currently in effect

## Operation
- Reset values: clk_o=0, rise_tick=0, fall_tick=0, running=0, div_cur=DIV_RESET, active mode=square, cnt=0, pending=0, state=IDLE.
- Shadow register: div_load captures div_val and mode_in and sets pending.
  - A second load before the boundary overwrites the first; the last one wins.
- Apply point: pending values become active, and pending clears, on either of:
  - the edge on which cnt==term (half-period boundary);
  - any edge in IDLE.
  - div_load coincident with that edge applies the div_val/mode_in presented on that same edge.
- Pulse mode with N=0 is clamped to N=1. div_cur reports the clamped value.
- Square mode:
  - each RUN/STOP edge: if cnt==N then toggle clk_o and set cnt=0, else cnt+1;
  - output period is 2(N+1) cycles.
- Pulse mode:
  - at cnt==N: clk_o=1 for the next cycle and cnt=0; otherwise clk_o=0;
  - output period is N+1 cycles, high for 1 cycle.
- FSM:
  - IDLE: cnt=0, clk_o=0. If en=1, go to RUN.
  - RUN: counting.
    - en=0 with clk_o=0 → IDLE on that edge; cnt clears and no tick is generated.
    - en=0 with clk_o=1 → STOP.
  - STOP: counting continues unchanged.
    - The edge that drives clk_o to 0 (with fall_tick) also enters IDLE.
    - en=1 while in STOP → RUN with no disturbance to cnt or clk_o.
- Invariant: every clk_o high phase has full length, including the final one before stop.
- Mode change while clk_o=1 in square mode:
  - applied at the boundary, which drives clk_o to 0;
  - pulse mode then starts its count from 0.

## Timing
- en sampled 1 at edge E in IDLE: state=RUN after E, cnt=0.
- First clk_o rise occurs at edge E+N+1. rise_tick is high in the cycle after that edge, together with clk_o=1.
- Ticks are registered on the same edge as clk_o. Latency from clk_o transition to tick is zero cycles.
- div_cur updates on the apply edge and is visible the following cycle.
- rst_n low forces all outputs to reset values immediately, with no clock needed. Release is sampled on the next rising clk edge.

## Test plan
- Reset, en=1, defaults (N=49999): first rise 50000 cycles after en edge; period 100000; high phase 50000; one rise_tick and one fall_tick per period.
- IDLE, div_load with div_val=3, then en=1: clk_o period 8, 4 high / 4 low; div_cur=3 one cycle after load.
- Running N=3, load div_val=1 at cnt=1: current half-period still lasts 4 cycles; then half-periods of 2; div_cur changes at that boundary. Two loads (5, then 1) before the boundary: only 1 takes effect.
- Pulse mode N=4: clk_o high 1 cycle in every 5; rise_tick/fall_tick one cycle apart. Load N=0 in pulse mode: div_cur=1, period 2.
- N=3 square, drop en 1 cycle into a high phase: clk_o stays high 3 more cycles, running=1 until the falling edge, then IDLE. Drop en during a low phase: IDLE next edge, clk_o=0, no tick. Re-raise en during STOP: running continues with no phase change.
- Assert rst_n mid-high-phase between clock edges: clk_o, ticks and running fall to 0 immediately; div_cur=49999; after release, en=1 gives first rise after N+1 cycles.
